// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single variable-latency memory port.
// Optional fetch starvation guard is compiled in with `define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          if_done,
    output logic          dm_done,
    output logic          if_stall,
    output logic          dm_stall,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ack,
    output logic [1:0]    addr_sel
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t state_r;
    logic   grant_if_s;
    logic   grant_dm_s;
    logic   fetch_first_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt_r;

    assign fetch_first_s = (starve_cnt_r == STARVE_LIM);

    // Count data grants taken while fetch was waiting; a fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_if_s) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_dm_s && if_req && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign fetch_first_s = 1'b0;
`endif

    // Winner selection, only evaluated in IDLE: data first unless fetch is being starved.
    always_comb begin
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        if (state_r == IDLE) begin
            if (if_req && (fetch_first_s || !dm_req)) begin
                grant_if_s = 1'b1;
            end else if (dm_req) begin
                grant_dm_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
            end
        end else begin
            grant_dm_s = 1'b0;
        end
    end

    // Completion is the acknowledge itself, qualified by the owning busy state.
    assign if_done  = (state_r == BUSY_IF) && ram_ack;
    assign dm_done  = (state_r == BUSY_DM) && ram_ack;
    assign if_stall = if_req && !if_done;
    assign dm_stall = dm_req && !dm_done;
    assign rdata    = ram_rdata;

    // Main FSM with registered memory-side outputs held stable for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            addr_sel  <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_dm_s) begin
                        state_r   <= BUSY_DM;
                        ram_en    <= 1'b1;
                        ram_we    <= dm_we;
                        ram_addr  <= dm_addr;
                        ram_wdata <= dm_wdata;
                        addr_sel  <= 2'b10;
                    end else if (grant_if_s) begin
                        state_r   <= BUSY_IF;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_wdata <= '0;
                        addr_sel  <= 2'b01;
                    end else begin
                        state_r   <= IDLE;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                        addr_sel  <= 2'b00;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (ram_ack) begin
                        state_r  <= IDLE;
                        ram_en   <= 1'b0;
                        ram_we   <= 1'b0;
                        addr_sel <= 2'b00;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    addr_sel <= 2'b00;
                end
            endcase
        end
    end

endmodule
